// File: rtl/uart_disp_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_disp_cmd_ctrl
// Brief    : Assembles 5-byte UART command frames and drives the display mode.
// Revision : 1.0
// ============================================================================
module uart_disp_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  HDR0           = 8'h55,
    parameter logic [7:0]  HDR1           = 8'hAA
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [7:0] I_uart_rdata,
    input  logic       I_uart_rvalid,
    output logic       O_split_en,
    output logic [1:0] O_full_ch,
    output logic       O_cfg_update,
    output logic       O_frame_err,
    output logic [7:0] O_err_cnt,
    output logic       O_busy
);

    localparam int unsigned          c_tmo_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_max   = c_tmo_w'(TIMEOUT_CYCLES);
    localparam logic [c_tmo_w-1:0]   c_tmo_one   = c_tmo_w'(1);
    localparam logic [7:0]           c_cmd_split = 8'h01;
    localparam logic [7:0]           c_cmd_full  = 8'h02;
    localparam logic [7:0]           c_err_max   = 8'hFF;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_CMD   = 3'd2,
        S_PARAM = 3'd3,
        S_CHK   = 3'd4
    } state_t;

    state_t               r_state_q,      w_state_d;
    logic                 r_rvalid_q;
    logic [7:0]           r_cmd_q,        w_cmd_d;
    logic [7:0]           r_param_q,      w_param_d;
    logic                 r_split_en_q,   w_split_en_d;
    logic [1:0]           r_full_ch_q,    w_full_ch_d;
    logic                 r_cfg_update_q, w_cfg_update_d;
    logic                 r_frame_err_q,  w_frame_err_d;
    logic [7:0]           r_err_cnt_q,    w_err_cnt_d;
    logic                 r_busy_q,       w_busy_d;
    logic [c_tmo_w-1:0]   r_tmo_cnt_q,    w_tmo_cnt_d;

    logic                 w_byte_acc;
    logic                 w_tmo_hit;
    logic                 w_err;
    logic [7:0]           w_sum;

    always_comb begin
        w_byte_acc     = I_uart_rvalid & ~r_rvalid_q;
        w_tmo_hit      = (r_tmo_cnt_q == c_tmo_max);
        w_sum          = r_cmd_q + r_param_q;
        w_err          = 1'b0;
        w_state_d      = r_state_q;
        w_cmd_d        = r_cmd_q;
        w_param_d      = r_param_q;
        w_split_en_d   = r_split_en_q;
        w_full_ch_d    = r_full_ch_q;
        w_cfg_update_d = 1'b0;
        w_frame_err_d  = 1'b0;
        w_err_cnt_d    = r_err_cnt_q;
        w_tmo_cnt_d    = r_tmo_cnt_q + c_tmo_one;

        // A byte arriving on the terminal-count cycle takes priority over the timeout.
        if (w_byte_acc) begin
            w_tmo_cnt_d = '0;
            case (r_state_q)
                S_HDR0: begin
                    if (I_uart_rdata == HDR0) w_state_d = S_HDR1;
                end
                S_HDR1: begin
                    if (I_uart_rdata == HDR1)      w_state_d = S_CMD;
                    else if (I_uart_rdata == HDR0) w_state_d = S_HDR1;
                    else                           w_state_d = S_HDR0;
                end
                S_CMD: begin
                    w_cmd_d   = I_uart_rdata;
                    w_state_d = S_PARAM;
                end
                S_PARAM: begin
                    w_param_d = I_uart_rdata;
                    w_state_d = S_CHK;
                end
                S_CHK: begin
                    w_state_d = S_HDR0;
                    if ((w_sum == I_uart_rdata) && (r_cmd_q == c_cmd_split)) begin
                        w_split_en_d   = 1'b1;
                        w_cfg_update_d = 1'b1;
                    end else if ((w_sum == I_uart_rdata) && (r_cmd_q == c_cmd_full) &&
                                 (r_param_q <= 8'd3)) begin
                        w_split_en_d   = 1'b0;
                        w_full_ch_d    = r_param_q[1:0];
                        w_cfg_update_d = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_state_d = S_HDR0;
            endcase
        end else if (r_state_q == S_HDR0) begin
            w_tmo_cnt_d = '0;
        end else if (w_tmo_hit) begin
            // A stall after only the first header byte is not counted as a frame.
            w_tmo_cnt_d = '0;
            w_state_d   = S_HDR0;
            w_err       = (r_state_q != S_HDR1);
        end

        if (w_err) begin
            w_frame_err_d = 1'b1;
            if (r_err_cnt_q != c_err_max) w_err_cnt_d = r_err_cnt_q + 8'd1;
        end

        w_busy_d = (w_state_d != S_HDR0);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state_q      <= S_HDR0;
            r_rvalid_q     <= 1'b0;
            r_cmd_q        <= 8'h00;
            r_param_q      <= 8'h00;
            r_split_en_q   <= 1'b1;
            r_full_ch_q    <= 2'd0;
            r_cfg_update_q <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_err_cnt_q    <= 8'h00;
            r_busy_q       <= 1'b0;
            r_tmo_cnt_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_rvalid_q     <= I_uart_rvalid;
            r_cmd_q        <= w_cmd_d;
            r_param_q      <= w_param_d;
            r_split_en_q   <= w_split_en_d;
            r_full_ch_q    <= w_full_ch_d;
            r_cfg_update_q <= w_cfg_update_d;
            r_frame_err_q  <= w_frame_err_d;
            r_err_cnt_q    <= w_err_cnt_d;
            r_busy_q       <= w_busy_d;
            r_tmo_cnt_q    <= w_tmo_cnt_d;
        end
    end

    assign O_split_en   = r_split_en_q;
    assign O_full_ch    = r_full_ch_q;
    assign O_cfg_update = r_cfg_update_q;
    assign O_frame_err  = r_frame_err_q;
    assign O_err_cnt    = r_err_cnt_q;
    assign O_busy       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_disp_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_disp_cmd_ctrl
// Brief    : Self-checking bench with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_disp_cmd_ctrl;

    localparam int TO = 100;

    logic       clk;
    logic       rst;
    logic [7:0] rdata;
    logic       rvalid;
    logic       split_en;
    logic [1:0] full_ch;
    logic       cfg_update;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_pulses = 0;
    int err_pulses = 0;

    uart_disp_cmd_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .HDR0           (8'h55),
        .HDR1           (8'hAA)
    ) dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_uart_rdata  (rdata),
        .I_uart_rvalid (rvalid),
        .O_split_en    (split_en),
        .O_full_ch     (full_ch),
        .O_cfg_update  (cfg_update),
        .O_frame_err   (frame_err),
        .O_err_cnt     (err_cnt),
        .O_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: partial frame held as a byte queue
    logic [7:0] m_frame[$];
    bit         m_live   = 1'b0;
    bit         m_prev_v = 1'b0;
    int         m_idle   = 0;
    bit         m_split  = 1'b1;
    logic [1:0] m_ch     = 2'd0;
    bit         m_upd    = 1'b0;
    bit         m_err    = 1'b0;
    int         m_cnt    = 0;

    task automatic m_take(input logic [7:0] b);
        int sum;
        bit ok;
        case (m_frame.size())
            0: if (b == 8'h55) m_frame.push_back(b);
            1: begin
                if (b == 8'hAA)      m_frame.push_back(b);
                else if (b != 8'h55) m_frame.delete();
            end
            4: begin
                sum = (int'(m_frame[2]) + int'(m_frame[3])) % 256;
                ok  = (sum == int'(b)) &&
                      ((m_frame[2] == 8'h01) || ((m_frame[2] == 8'h02) && (m_frame[3] <= 8'd3)));
                if (ok) begin
                    m_upd = 1'b1;
                    if (m_frame[2] == 8'h01) m_split = 1'b1;
                    else begin
                        m_split = 1'b0;
                        m_ch    = m_frame[3][1:0];
                    end
                end else begin
                    m_err = 1'b1;
                end
                m_frame.delete();
            end
            default: m_frame.push_back(b);
        endcase
    endtask

    task automatic m_step(input bit r, input bit v, input logic [7:0] d);
        if (r) begin
            m_live = 1'b1; m_prev_v = 1'b0; m_idle = 0;
            m_split = 1'b1; m_ch = 2'd0; m_upd = 1'b0; m_err = 1'b0; m_cnt = 0;
            m_frame.delete();
        end else begin
            m_upd = 1'b0;
            m_err = 1'b0;
            if (v && !m_prev_v) begin
                m_idle = 0;
                m_take(d);
            end else if (m_frame.size() == 0) begin
                m_idle = 0;
            end else if (m_idle == TO) begin
                m_err  = (m_frame.size() >= 2);
                m_idle = 0;
                m_frame.delete();
            end else begin
                m_idle++;
            end
            m_prev_v = v;
            if (m_err && m_cnt < 255) m_cnt++;
        end
    endtask

    always @(posedge clk) begin
        logic [13:0] exp_v;
        logic [13:0] act_v;
        m_step(rst, rvalid, rdata);
        #1;
        if (cfg_update === 1'b1) upd_pulses++;
        if (frame_err === 1'b1)  err_pulses++;
        if (m_live) begin
            exp_v = {m_split, m_ch, m_upd, m_err, 8'(m_cnt), (m_frame.size() != 0)};
            act_v = {split_en, full_ch, cfg_update, frame_err, err_cnt, busy};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got split=%b ch=%0d upd=%b err=%b cnt=%0d busy=%b, expected split=%b ch=%0d upd=%b err=%b cnt=%0d busy=%b",
                         $time, act_v[13], act_v[12:11], act_v[10], act_v[9], act_v[8:1], act_v[0],
                         exp_v[13], exp_v[12:11], exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rdata  = b;
        rvalid = 1'b1;
        @(posedge clk);
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int hold);
        send_byte(b0, hold);
        send_byte(b1, hold);
        send_byte(b2, hold);
        send_byte(b3, hold);
        send_byte(b4, hold);
    endtask

    initial begin
        int k;
        rst = 1'b1; rvalid = 1'b0; rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_split_en", int'(split_en), 1);
        check("reset_full_ch",  int'(full_ch), 0);
        check("reset_err_cnt",  int'(err_cnt), 0);
        check("reset_busy",     int'(busy), 0);
        rst = 1'b0;

        send_frame(8'h55, 8'hAA, 8'h02, 8'h02, 8'h04, 1);
        check("full_ch2_split", int'(split_en), 0);
        check("full_ch2_ch",    int'(full_ch), 2);
        check("full_ch2_upd",   upd_pulses, 1);
        check("full_ch2_cnt",   int'(err_cnt), 0);

        send_frame(8'h55, 8'hAA, 8'h01, 8'h00, 8'h01, 1);
        check("split_split", int'(split_en), 1);
        check("split_ch",    int'(full_ch), 2);
        send_frame(8'h55, 8'hAA, 8'h02, 8'h05, 8'h07, 1);
        check("bad_param_cnt",  int'(err_cnt), 1);
        check("bad_param_errp", err_pulses, 1);
        check("bad_param_ch",   int'(full_ch), 2);

        send_frame(8'h55, 8'hAA, 8'h02, 8'h01, 8'h00, 1);
        check("bad_chk_cnt", int'(err_cnt), 2);
        check("bad_chk_upd", upd_pulses, 2);
        send_byte(8'h55, 1);
        send_frame(8'h55, 8'hAA, 8'h02, 8'h03, 8'h05, 1);
        check("resync_split", int'(split_en), 0);
        check("resync_ch",    int'(full_ch), 3);

        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h02, 1);
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(posedge clk);
            #1;
            if (frame_err === 1'b1) begin
                k = i;
                break;
            end
        end
        check("timeout_latency", k, TO + 1);
        check("timeout_busy",    int'(busy), 0);
        check("timeout_cnt",     int'(err_cnt), 3);
        send_frame(8'h55, 8'hAA, 8'h01, 8'h05, 8'h06, 1);
        check("after_timeout_split", int'(split_en), 1);
        check("after_timeout_upd",   upd_pulses, 4);

        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        repeat (TO) @(posedge clk);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        check("terminal_byte_errp", err_pulses, 3);
        check("terminal_byte_ch",   int'(full_ch), 0);
        check("terminal_byte_split", int'(split_en), 0);

        send_frame(8'h55, 8'hAA, 8'h02, 8'h01, 8'h03, 3);
        check("hold3_ch",  int'(full_ch), 1);
        check("hold3_upd", upd_pulses, 6);

        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h02, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_split", int'(split_en), 1);
        check("rst_mid_ch",    int'(full_ch), 0);
        check("rst_mid_cnt",   int'(err_cnt), 0);
        check("rst_mid_busy",  int'(busy), 0);
        check("rst_mid_errp",  err_pulses, 3);

        for (int f = 0; f < 260; f++) send_frame(8'h55, 8'hAA, 8'h03, 8'h00, 8'h03, 1);
        check("saturate_cnt", int'(err_cnt), 255);
        check("saturate_split", int'(split_en), 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
